// File: rtl/neokeon_pkg.sv
// ---------------------------------------------------------------------------
// neokeon_pkg
//   Shared constants and elaboration-time helpers for the Neokeon datapath
//   blocks.
//   - NEOKEON_BLOCK_W : native Neokeon block width (128 bits)
//   - nw_of()         : number of output words per block
//   - idx_w_of()      : width of a word index (at least 1 bit)
//   - cnt_w_of()      : width of an occupancy counter able to hold 0..depth
// ---------------------------------------------------------------------------
package neokeon_pkg;

  localparam int NEOKEON_BLOCK_W = 128;

  // Words per block; the block width is expected to be an exact multiple
  // of the word width.
  function automatic int nw_of(input int block_w, input int out_w);
    return block_w / out_w;
  endfunction

  // A single-word block still needs a 1-bit index signal.
  function automatic int idx_w_of(input int nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

  // Counter must represent the full state (depth), hence depth+1 values.
  function automatic int cnt_w_of(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/neokeon_word_sel.sv
// ---------------------------------------------------------------------------
// neokeon_word_sel
//   Pure combinational mux returning word idx_i of a BLOCK_W-wide vector.
//   With MSW_FIRST=1 word 0 is the most-significant OUT_W slice, otherwise
//   word 0 is the least-significant slice.
//   Ports:
//     block_i : block being serialised
//     idx_i   : word index, 0..NW-1
//     word_o  : selected OUT_W-bit word (0 for an out-of-range index)
// ---------------------------------------------------------------------------
module neokeon_word_sel
  import neokeon_pkg::*;
#(
  parameter int BLOCK_W   = NEOKEON_BLOCK_W,
  parameter int OUT_W     = 32,
  parameter int MSW_FIRST = 1,
  localparam int NW       = nw_of(BLOCK_W, OUT_W),
  localparam int IDX_W    = idx_w_of(NW)
) (
  input  logic [BLOCK_W-1:0] block_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [OUT_W-1:0]   word_o
);

  always_comb begin
    word_o = '0;
    for (int k = 0; k < NW; k++) begin
      if (idx_i == IDX_W'(k)) begin
        if (MSW_FIRST != 0) begin
          word_o = block_i[BLOCK_W-1-k*OUT_W -: OUT_W];
        end else begin
          word_o = block_i[k*OUT_W +: OUT_W];
        end
      end
    end
  end

endmodule

// File: rtl/neokeon_data_out_fifo.sv
// ---------------------------------------------------------------------------
// neokeon_data_out_fifo
//   Output buffer between the Neokeon round core and the host interface.
//   Holds up to DEPTH finished blocks and streams the head block out as
//   BLOCK_W/OUT_W words over a valid/ready handshake.
//   Ports:
//     inClk, inRstN : clock (rising edge), asynchronous active-low reset
//     inWr, inData  : push one block (dropped while the FIFO is full)
//     inFlush       : synchronous clear of contents and status
//     inReady       : consumer takes outData this cycle
//     outData       : current word of the head block (0 when not valid)
//     outValid      : outData is valid
//     outLast       : current word is the last word of its block
//     outFull       : DEPTH blocks stored
//     outCount      : blocks stored, including one partially sent
//     outOverflow   : sticky, set when a push was dropped
//   Every output is derived from registers only.
// ---------------------------------------------------------------------------
module neokeon_data_out_fifo
  import neokeon_pkg::*;
#(
  parameter int BLOCK_W   = NEOKEON_BLOCK_W,
  parameter int OUT_W     = 32,
  parameter int DEPTH     = 4,
  parameter int MSW_FIRST = 1
) (
  input  logic                       inClk,
  input  logic                       inRstN,
  input  logic                       inWr,
  input  logic [BLOCK_W-1:0]         inData,
  input  logic                       inFlush,
  input  logic                       inReady,
  output logic [OUT_W-1:0]           outData,
  output logic                       outValid,
  output logic                       outLast,
  output logic                       outFull,
  output logic [cnt_w_of(DEPTH)-1:0] outCount,
  output logic                       outOverflow
);

  localparam int NW    = nw_of(BLOCK_W, OUT_W);
  localparam int IDX_W = idx_w_of(NW);
  localparam int CNT_W = cnt_w_of(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [BLOCK_W-1:0] mem_q [DEPTH];
  logic [BLOCK_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic               overflow_q, overflow_d;

  logic               full;
  logic               valid;
  logic               last_word;
  logic               xfer;
  logic               push;
  logic               pop;
  logic [BLOCK_W-1:0] head_blk;
  logic [OUT_W-1:0]   head_word;

  // Status comes from the registered count, so a push in the same cycle
  // as the final-word pop of a full FIFO is still refused.
  assign full      = (count_q == FULL_CNT);
  assign valid     = (count_q != '0);
  assign last_word = (word_idx_q == LAST_IDX);
  assign xfer      = valid && inReady;
  assign pop       = xfer && last_word;
  assign push      = inWr && !full;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    overflow_d = overflow_q;

    if (inFlush) begin
      // Flush wins over any concurrent push or pop; stored data is left
      // in place because it is unreachable once the pointers are cleared.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      word_idx_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = inData;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end

      if (inWr && full) begin
        overflow_d = 1'b1;
      end

      if (xfer) begin
        if (last_word) begin
          word_idx_d = '0;
          rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        end else begin
          word_idx_d = word_idx_q + IDX_W'(1);
        end
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      overflow_q <= overflow_d;
    end
  end

  assign head_blk = mem_q[rd_ptr_q];

  neokeon_word_sel #(
    .BLOCK_W   (BLOCK_W),
    .OUT_W     (OUT_W),
    .MSW_FIRST (MSW_FIRST)
  ) u_word_sel (
    .block_i (head_blk),
    .idx_i   (word_idx_q),
    .word_o  (head_word)
  );

  assign outData     = valid ? head_word : '0;
  assign outValid    = valid;
  assign outLast     = valid && last_word;
  assign outFull     = full;
  assign outCount    = count_q;
  assign outOverflow = overflow_q;

endmodule

// File: tb/tb_neokeon_data_out_fifo.sv
// ---------------------------------------------------------------------------
// tb_neokeon_data_out_fifo
//   Bench for neokeon_data_out_fifo. Two instances share the inputs: one
//   sending the most-significant word first, one the least-significant.
//   A queue-based reference model tracks stored blocks, the word position
//   within the head block and the sticky overflow flag.
// ---------------------------------------------------------------------------
module tb_neokeon_data_out_fifo;

  localparam int BLOCK_W = 128;
  localparam int OUT_W   = 32;
  localparam int DEPTH   = 4;
  localparam int NW      = BLOCK_W / OUT_W;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               wr    = 1'b0;
  logic               flush = 1'b0;
  logic               ready = 1'b0;
  logic [BLOCK_W-1:0] din   = '0;

  logic [OUT_W-1:0] m_data,  l_data;
  logic             m_valid, l_valid;
  logic             m_last,  l_last;
  logic             m_full,  l_full;
  logic [2:0]       m_count, l_count;
  logic             m_ovf,   l_ovf;

  logic [38:0] got_m, got_l;
  assign got_m = {m_valid, m_last, m_full, m_count, m_ovf, m_data};
  assign got_l = {l_valid, l_last, l_full, l_count, l_ovf, l_data};

  always #5 clk = ~clk;

  neokeon_data_out_fifo #(
    .BLOCK_W(BLOCK_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .MSW_FIRST(1)
  ) dut (
    .inClk(clk), .inRstN(rst_n), .inWr(wr), .inData(din), .inFlush(flush),
    .inReady(ready), .outData(m_data), .outValid(m_valid), .outLast(m_last),
    .outFull(m_full), .outCount(m_count), .outOverflow(m_ovf)
  );

  neokeon_data_out_fifo #(
    .BLOCK_W(BLOCK_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .MSW_FIRST(0)
  ) dut_lsw (
    .inClk(clk), .inRstN(rst_n), .inWr(wr), .inData(din), .inFlush(flush),
    .inReady(ready), .outData(l_data), .outValid(l_valid), .outLast(l_last),
    .outFull(l_full), .outCount(l_count), .outOverflow(l_ovf)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [BLOCK_W-1:0] m_q [$];
  int                 m_widx = 0;
  bit                 m_ovf_r = 1'b0;

  // Expected {valid,last,full,count,overflow,data} from the model.
  function automatic logic [38:0] model_vec(input bit msw);
    logic [OUT_W-1:0] w;
    logic             v;
    logic             l;
    logic             f;
    int               k;
    w = '0;
    v = (m_q.size() != 0);
    l = v && (m_widx == NW - 1);
    f = (m_q.size() == DEPTH);
    if (v) begin
      k = msw ? (NW - 1 - m_widx) : m_widx;
      w = OUT_W'(m_q[0] >> (k * OUT_W));
    end
    return {v, l, f, 3'(m_q.size()), m_ovf_r, w};
  endfunction

  function automatic logic [OUT_W-1:0] msw_word(input logic [BLOCK_W-1:0] b, input int k);
    return OUT_W'(b >> ((NW - 1 - k) * OUT_W));
  endfunction

  function automatic logic [BLOCK_W-1:0] rnd_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_widx  = 0;
    m_ovf_r = 1'b0;
  endtask

  // Advance the model with the inputs presented for the coming edge.
  task automatic model_edge();
    bit was_full;
    bit do_pop;
    do_pop = 1'b0;
    if (flush) begin
      model_reset();
      return;
    end
    was_full = (m_q.size() == DEPTH);
    if (m_q.size() != 0 && ready) begin
      if (m_widx == NW - 1) begin
        do_pop = 1'b1;
        m_widx = 0;
      end else begin
        m_widx++;
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (wr) begin
      if (was_full) m_ovf_r = 1'b1;
      else          m_q.push_back(din);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (got_m !== 39'd0 || got_l !== 39'd0)
      $display("FAIL reset_hold got %h/%h exp 0", got_m, got_l);
    else n_pass++;
    #3 rst_n = 1'b1;
    step();
    n_checks++;
    if (got_m !== model_vec(1) || got_l !== model_vec(0))
      $display("FAIL reset_release got %h/%h exp %h/%h", got_m, got_l, model_vec(1), model_vec(0));
    else n_pass++;
  endtask

  task automatic test_single();
    logic [OUT_W-1:0] ew [NW];
    ew = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    din   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    wr    = 1'b1;
    ready = 1'b1;
    step();
    wr = 1'b0;
    for (int k = 0; k < NW; k++) begin
      n_checks++;
      if (got_m !== model_vec(1) || got_l !== model_vec(0))
        $display("FAIL single_model w%0d got %h/%h exp %h/%h", k, got_m, got_l, model_vec(1), model_vec(0));
      else n_pass++;
      n_checks++;
      if (m_data !== ew[k] || m_last !== (k == NW - 1) || m_count !== 3'd1 || m_valid !== 1'b1)
        $display("FAIL single_word w%0d got data=%h last=%b cnt=%0d exp data=%h last=%b cnt=1",
                 k, m_data, m_last, m_count, ew[k], (k == NW - 1));
      else n_pass++;
      step();
    end
    n_checks++;
    if (m_valid !== 1'b0 || m_count !== 3'd0 || m_data !== '0)
      $display("FAIL single_empty got valid=%b cnt=%0d data=%h exp 0/0/0", m_valid, m_count, m_data);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [BLOCK_W-1:0] blk [5];
    flush = 1'b1;
    step();
    flush = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      blk[i] = rnd_block();
      din    = blk[i];
      wr     = 1'b1;
      step();
      n_checks++;
      if (got_m !== model_vec(1) || got_l !== model_vec(0))
        $display("FAIL ovf_push%0d got %h/%h exp %h/%h", i, got_m, got_l, model_vec(1), model_vec(0));
      else n_pass++;
    end
    wr = 1'b0;
    n_checks++;
    if (m_full !== 1'b1 || m_count !== 3'd4 || m_ovf !== 1'b1)
      $display("FAIL ovf_status got full=%b cnt=%0d ovf=%b exp 1/4/1", m_full, m_count, m_ovf);
    else n_pass++;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NW; k++) begin
        n_checks++;
        if (m_data !== msw_word(blk[i], k) || m_valid !== 1'b1)
          $display("FAIL ovf_drain b%0d w%0d got %h exp %h", i, k, m_data, msw_word(blk[i], k));
        else n_pass++;
        n_checks++;
        if (got_m !== model_vec(1) || got_l !== model_vec(0))
          $display("FAIL ovf_model b%0d w%0d got %h/%h exp %h/%h", i, k, got_m, got_l, model_vec(1), model_vec(0));
        else n_pass++;
        step();
      end
    end
    n_checks++;
    if (m_valid !== 1'b0 || m_count !== 3'd0)
      $display("FAIL ovf_empty got valid=%b cnt=%0d exp 0/0", m_valid, m_count);
    else n_pass++;
  endtask

  task automatic test_full_pop_push();
    flush = 1'b1;
    ready = 1'b0;
    step();
    flush = 1'b0;
    n_checks++;
    if (m_ovf !== 1'b0)
      $display("FAIL fpp_flush_ovf got %b exp 0", m_ovf);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      din = rnd_block();
      wr  = 1'b1;
      step();
    end
    wr    = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < NW - 1; i++) step();
    n_checks++;
    if (m_last !== 1'b1 || m_full !== 1'b1)
      $display("FAIL fpp_pre got last=%b full=%b exp 1/1", m_last, m_full);
    else n_pass++;
    din = rnd_block();
    wr  = 1'b1;
    step();
    wr = 1'b0;
    n_checks++;
    if (m_count !== 3'd3 || m_ovf !== 1'b1 || m_full !== 1'b0)
      $display("FAIL fpp_status got cnt=%0d ovf=%b full=%b exp 3/1/0", m_count, m_ovf, m_full);
    else n_pass++;
    n_checks++;
    if (got_m !== model_vec(1) || got_l !== model_vec(0))
      $display("FAIL fpp_model got %h/%h exp %h/%h", got_m, got_l, model_vec(1), model_vec(0));
    else n_pass++;
  endtask

  task automatic test_random_stall();
    logic [OUT_W-1:0] exp_w [$];
    logic [OUT_W-1:0] rcv_w [$];
    logic [OUT_W-1:0] held;
    bit               stalled;
    int               n_pushed;
    int               cyc;
    int               bad;
    flush = 1'b1;
    wr    = 1'b0;
    step();
    flush    = 1'b0;
    n_pushed = 0;
    cyc      = 0;
    while ((n_pushed < 8 || m_q.size() != 0) && cyc < 600) begin
      wr = (n_pushed < 8) && ($urandom_range(0, 1) == 1);
      if (wr) begin
        din = rnd_block();
        if (m_q.size() != DEPTH) begin
          for (int k = 0; k < NW; k++) exp_w.push_back(msw_word(din, k));
          n_pushed++;
        end
      end
      ready = ($urandom_range(0, 1) == 1);
      if (m_valid && ready) rcv_w.push_back(m_data);
      stalled = m_valid && !ready;
      held    = m_data;
      step();
      if (stalled) begin
        n_checks++;
        if (m_data !== held)
          $display("FAIL stall_hold cyc%0d got %h exp %h", cyc, m_data, held);
        else n_pass++;
      end
      n_checks++;
      if (got_m !== model_vec(1) || got_l !== model_vec(0))
        $display("FAIL stall_model cyc%0d got %h/%h exp %h/%h", cyc, got_m, got_l, model_vec(1), model_vec(0));
      else n_pass++;
      cyc++;
    end
    wr    = 1'b0;
    ready = 1'b0;
    n_checks++;
    if (cyc >= 600)
      $display("FAIL stall_timeout got %0d cycles exp fewer than 600", cyc);
    else n_pass++;
    bad = 0;
    if (rcv_w.size() != exp_w.size()) bad = 1;
    else for (int i = 0; i < exp_w.size(); i++) if (rcv_w[i] !== exp_w[i]) bad = 1;
    n_checks++;
    if (bad != 0 || exp_w.size() != 8 * NW)
      $display("FAIL stall_stream got %0d words exp %0d in order", rcv_w.size(), 8 * NW);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [BLOCK_W-1:0] nb;
    flush = 1'b1;
    step();
    flush = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = rnd_block();
      wr  = 1'b1;
      step();
    end
    wr    = 1'b0;
    ready = 1'b1;
    step();
    step();
    ready = 1'b1;
    flush = 1'b1;
    wr    = 1'b1;
    din   = rnd_block();
    step();
    flush = 1'b0;
    wr    = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || m_count !== 3'd0 || m_ovf !== 1'b0 || m_data !== '0 || m_full !== 1'b0)
      $display("FAIL flush_status got valid=%b cnt=%0d ovf=%b data=%h exp 0/0/0/0",
               m_valid, m_count, m_ovf, m_data);
    else n_pass++;
    nb    = rnd_block();
    din   = nb;
    wr    = 1'b1;
    ready = 1'b0;
    step();
    wr = 1'b0;
    n_checks++;
    if (m_data !== msw_word(nb, 0) || m_last !== 1'b0 || m_count !== 3'd1)
      $display("FAIL flush_restart got data=%h cnt=%0d exp %h/1", m_data, m_count, msw_word(nb, 0));
    else n_pass++;
    n_checks++;
    if (got_m !== model_vec(1) || got_l !== model_vec(0))
      $display("FAIL flush_model got %h/%h exp %h/%h", got_m, got_l, model_vec(1), model_vec(0));
    else n_pass++;
  endtask

  task automatic test_async_reset();
    ready = 1'b1;
    step();
    ready = 1'b0;
    n_checks++;
    if (m_valid !== 1'b1)
      $display("FAIL arst_pre got valid=%b exp 1", m_valid);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (got_m !== 39'd0 || got_l !== 39'd0)
      $display("FAIL arst_zero got %h/%h exp 0", got_m, got_l);
    else n_pass++;
    model_reset();
    #1 rst_n = 1'b1;
    din = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    wr  = 1'b1;
    step();
    wr = 1'b0;
    n_checks++;
    if (l_data !== 32'hCCDDEEFF || m_data !== 32'h00112233)
      $display("FAIL arst_order got lsw=%h msw=%h exp CCDDEEFF/00112233", l_data, m_data);
    else n_pass++;
    n_checks++;
    if (got_m !== model_vec(1) || got_l !== model_vec(0))
      $display("FAIL arst_model got %h/%h exp %h/%h", got_m, got_l, model_vec(1), model_vec(0));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_pop_push();
    test_random_stall();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
